// File: rtl/flopr_pipe.sv
// Elastic N-stage pipeline register chain: per-stage valid bits, valid/ready handshake,
// bubble collapsing, synchronous flush and a registered occupancy count.
module flopr_pipe #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] incoming;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             in_fire;

  // Ripple from the output end: a stage advances if the next one is empty or advancing too.
  always_comb begin
    move = '0;
    move[DEPTH-1] = v_q[DEPTH-1] & out_ready & ~flush;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      move[i] = v_q[i] & (~v_q[i+1] | move[i+1]) & ~flush;
    end
  end

  assign in_ready  = (~v_q[0] | move[0]) & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  always_comb begin
    incoming = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        incoming[i] = in_fire;
      end else begin
        incoming[i] = move[i-1];
      end
    end
    v_d = flush ? '0 : (incoming | (v_q & ~move));
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      // Flush clears valids only; payload registers keep their contents.
      if (incoming[0]) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (incoming[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed bench for flopr_pipe: a DEPTH=3 cycle table plus a DEPTH=1 reset sequence.
module tb_flopr_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=3 instance
  logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  flopr_pipe #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'h0)) u_dut_a (
    .clk       (clk),
    .reset     (a_reset),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
  );

  // DEPTH=1 instance
  logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic        b_count;

  flopr_pipe #(.WIDTH(64), .DEPTH(1), .RESET_VAL(64'hFFFF)) u_dut_b (
    .clk       (clk),
    .reset     (b_reset),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
  );

  typedef struct {
    logic        chk;
    logic        rst;
    logic        fl;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [63:0] e_od;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic chk, logic rst, logic fl, logic iv, logic [63:0] id,
                              logic ordy, logic e_irdy, logic e_ov, logic [63:0] e_od,
                              int e_cnt);
    vec_t v;
    v.chk = chk; v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // chk rst fl iv id ordy | irdy ov od cnt ; each row is one cycle, checked before its edge
    vecs.push_back(mk(0, 1, 0, 1, 64'h5, 0, 0, 0, 64'h0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 64'h5, 0, 1, 0, 64'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 0, 64'h0, 0));
    // streaming 1..A
    vecs.push_back(mk(1, 0, 0, 1, 64'h1, 1, 1, 0, 64'h0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 64'h2, 1, 1, 0, 64'h0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 64'h3, 1, 1, 0, 64'h0, 2));
    for (int k = 4; k <= 10; k++) begin
      vecs.push_back(mk(1, 0, 0, 1, 64'(k), 1, 1, 1, 64'(k - 3), 3));
    end
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h8, 3));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h9, 2));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'hA, 1));
    // backpressure fill
    vecs.push_back(mk(1, 0, 0, 1, 64'h1, 0, 1, 0, 64'hA, 0));
    vecs.push_back(mk(1, 0, 0, 1, 64'h2, 0, 1, 0, 64'hA, 1));
    vecs.push_back(mk(1, 0, 0, 1, 64'h3, 0, 1, 0, 64'hA, 2));
    vecs.push_back(mk(1, 0, 0, 1, 64'h4, 0, 0, 1, 64'h1, 3));
    vecs.push_back(mk(1, 0, 0, 1, 64'h4, 1, 1, 1, 64'h1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h3, 2));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h4, 1));
    // bubble collapse
    vecs.push_back(mk(1, 0, 0, 1, 64'h7, 0, 1, 0, 64'h4, 0));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, 1, 0, 64'h4, 1));
    vecs.push_back(mk(1, 0, 0, 1, 64'h8, 0, 1, 0, 64'h4, 1));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, 1, 1, 64'h7, 2));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, 1, 1, 64'h7, 2));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h7, 2));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 1, 64'h8, 1));
    // flush with chain full
    vecs.push_back(mk(1, 0, 0, 1, 64'h1, 0, 1, 0, 64'h8, 0));
    vecs.push_back(mk(1, 0, 0, 1, 64'h2, 0, 1, 0, 64'h8, 1));
    vecs.push_back(mk(1, 0, 0, 1, 64'h3, 0, 1, 0, 64'h8, 2));
    vecs.push_back(mk(1, 0, 1, 1, 64'h9, 1, 0, 0, 64'h1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 0, 64'h1, 0));
    // multi-cycle flush
    vecs.push_back(mk(1, 0, 1, 1, 64'hB, 1, 0, 0, 64'h1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 64'hB, 1, 0, 0, 64'h1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 1, 1, 0, 64'h1, 0));
    // reset with an entry in flight reloads data registers
    vecs.push_back(mk(1, 0, 0, 1, 64'hC, 0, 1, 0, 64'h1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 64'h0, 0, 1, 0, 64'h1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, 1, 0, 64'h0, 0));

    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      a_reset     = vecs[k].rst;
      a_flush     = vecs[k].fl;
      a_in_valid  = vecs[k].iv;
      a_in_data   = vecs[k].id;
      a_out_ready = vecs[k].ordy;
      #1;
      if (vecs[k].chk) begin
        check($sformatf("v%0d in_ready", k),  64'(a_in_ready),  64'(vecs[k].e_irdy));
        check($sformatf("v%0d out_valid", k), 64'(a_out_valid), 64'(vecs[k].e_ov));
        check($sformatf("v%0d out_data", k),  a_out_data,       vecs[k].e_od);
        check($sformatf("v%0d count", k),     64'(a_count),     64'(vecs[k].e_cnt));
      end
    end

    // DEPTH=1, RESET_VAL=FFFF: b_reset held high through the table above
    @(negedge clk);
    b_reset = 1'b0;
    #1;
    check("b reset out_valid", 64'(b_out_valid), 64'h0);
    check("b reset out_data",  b_out_data,        64'hFFFF);
    check("b reset in_ready",  64'(b_in_ready),  64'h1);
    b_in_valid = 1'b1; b_in_data = 64'h2;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_data = 64'h0;
    #1;
    check("b hold out_valid", 64'(b_out_valid), 64'h1);
    check("b hold out_data",  b_out_data,        64'h2);
    check("b hold count",     64'(b_count),     64'h1);
    check("b full in_ready",  64'(b_in_ready),  64'h0);
    @(negedge clk);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    #1;
    check("b rst2 out_valid", 64'(b_out_valid), 64'h0);
    check("b rst2 out_data",  b_out_data,        64'hFFFF);
    check("b rst2 count",     64'(b_count),     64'h0);
    b_in_valid = 1'b1; b_in_data = 64'h3; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_data = 64'h4;
    #1;
    check("b new out_valid", 64'(b_out_valid), 64'h1);
    check("b new out_data",  b_out_data,        64'h3);
    check("b pass in_ready", 64'(b_in_ready),  64'h1);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check("b next out_data", b_out_data,     64'h4);
    check("b next count",    64'(b_count),  64'h1);
    @(negedge clk);
    #1;
    check("b drain out_valid", 64'(b_out_valid), 64'h0);
    check("b drain count",     64'(b_count),     64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
